tick_checker: RTL and testbench

Receive-side monitor for the periodic one-cycle tick produced by the design's modulo-N pulse generators. Samples the tick stream, confirms it arrives exactly every PERIOD clocks, declares lock after LOCK_COUNT consecutive correct intervals, and flags early or missing ticks with one-cycle error pulses and a saturating error counter. Sits downstream of the tick generator, for example on a clock-enable fan-out or as a bring-up and health monitor.

---
 rtl/tick_checker.sv | 157 +++++++++++++++
 tb/tb_tick_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_checker.sv
`default_nettype none
// ============================================================================
// Module   : tick_checker
// Purpose  : Receive-side monitor for a periodic one-cycle tick. Checks that
//            ticks arrive exactly every PERIOD clocks, declares lock after
//            LOCK_COUNT consecutive correct intervals, and reports early or
//            missing ticks with one-cycle pulses and a saturating counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PERIOD     expected tick interval in clocks (>= 2)
//   LOCK_COUNT consecutive correct intervals needed for lock (>= 1)
//   ERR_W      width of err_count
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   tick_in    tick from the generator (one high cycle = one tick)
//   err_clr    synchronous clear of err_count
//   locked     high while the checker is in LOCKED
//   short_err  one-cycle pulse: tick arrived early while locked
//   miss_err   one-cycle pulse: expected tick absent while locked
//   err_count  saturating count of short_err + miss_err events
// ============================================================================
module tick_checker #(
  parameter int PERIOD     = 5,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             short_err,
  output logic             miss_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int GAP_W  = $clog2(PERIOD + 2);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [GAP_W-1:0]  GAP_PERIOD = GAP_W'(PERIOD);
  localparam logic [GAP_W-1:0]  GAP_MAX    = GAP_W'(PERIOD + 1);
  localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE   = GOOD_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
  localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [GAP_W-1:0]    gap;
  logic [GOOD_W-1:0]   good;
  logic [GOOD_W-1:0]   good_nxt;
  logic [GOOD_W-1:0]   good_inc;
  logic                gap_is_period;
  logic                short_nxt;
  logic                miss_nxt;

  // gap holds the clocks since the last tick; its value on a tick cycle is
  // the measured interval. Saturating at PERIOD+1 keeps a long silence from
  // wrapping back into a value that could look like a correct interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap <= '0;
    end else if (tick_in) begin
      gap <= GAP_ONE;
    end else if (gap != GAP_MAX) begin
      gap <= gap + GAP_ONE;
    end
  end

  assign gap_is_period = (gap == GAP_PERIOD);
  assign good_inc      = good + GOOD_ONE;

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    short_nxt = 1'b0;
    miss_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (tick_in) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
        end
      end
      SEARCH: begin
        if (tick_in) begin
          if (gap_is_period) begin
            good_nxt = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_nxt = LOCKED;
            end
          end else begin
            // Wrong interval: this tick becomes the new anchor.
            good_nxt = '0;
          end
        end else if (gap_is_period) begin
          good_nxt = '0;
        end
      end
      LOCKED: begin
        if (tick_in) begin
          // While locked a tick can only be on time or early, since a
          // silent PERIOD already left this state.
          if (!gap_is_period) begin
            short_nxt = 1'b1;
            state_nxt = SEARCH;
            good_nxt  = '0;
          end
        end else if (gap_is_period) begin
          miss_nxt  = 1'b1;
          state_nxt = IDLE;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      good      <= '0;
      locked    <= 1'b0;
      short_err <= 1'b0;
      miss_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      good      <= good_nxt;
      locked    <= (state_nxt == LOCKED);
      short_err <= short_nxt;
      miss_err  <= miss_nxt;
    end
  end

  // Clear wins over a coincident error; the error pulse itself still fires.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count <= '0;
    end else if ((short_nxt || miss_nxt) && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_checker
// Purpose  : Directed self-checking bench for tick_checker (PERIOD=5,
//            LOCK_COUNT=3, ERR_W=2). Inputs change 1 ns after a rising edge
//            and outputs are sampled at that same point, so each step shows
//            the result of the edge just taken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       err_clr = 1'b0;
  logic       locked;
  logic       short_err;
  logic       miss_err;
  logic [1:0] err_count;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int short_cnt = 0;
  int miss_cnt  = 0;
  int both_cnt  = 0;

  tick_checker #(
    .PERIOD     (5),
    .LOCK_COUNT (3),
    .ERR_W      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .err_clr   (err_clr),
    .locked    (locked),
    .short_err (short_err),
    .miss_err  (miss_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock edge with the given inputs; tallies error pulses seen after it.
  task automatic step(input logic t, input logic c);
    tick_in = t;
    err_clr = c;
    @(posedge clk);
    #1;
    if (short_err) short_cnt++;
    if (miss_err) miss_cnt++;
    if (short_err && miss_err) both_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // A tick exactly one PERIOD after the previous tick.
  task automatic next_tick();
    idle(4);
    step(1'b1, 1'b0);
  endtask

  // From any state: anchor tick plus three correct intervals reaches lock.
  task automatic acquire();
    idle(1);
    step(1'b1, 1'b0);
    next_tick();
    next_tick();
    next_tick();
  endtask

  initial begin
    int s0;
    int m0;

    // ---------------- reset ----------------
    rst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_short", int'(short_err), 0);
    chk("rst_miss", int'(miss_err), 0);
    chk("rst_errcnt", int'(err_count), 0);
    rst = 1'b0;

    // ---------------- lock-up ----------------
    short_cnt = 0; miss_cnt = 0;
    idle(1);
    step(1'b1, 1'b0);
    chk("lock_anchor_locked", int'(locked), 0);
    next_tick();
    chk("lock_int1_locked", int'(locked), 0);
    next_tick();
    chk("lock_int2_locked", int'(locked), 0);
    next_tick();
    chk("lock_int3_locked", int'(locked), 1);
    next_tick();
    chk("lock_hold_locked", int'(locked), 1);
    chk("lock_no_short", short_cnt, 0);
    chk("lock_no_miss", miss_cnt, 0);
    chk("lock_errcnt", int'(err_count), 0);

    // ---------------- miss ----------------
    idle(4);
    chk("miss_pre_flag", int'(miss_err), 0);
    chk("miss_pre_locked", int'(locked), 1);
    idle(1);
    chk("miss_flag", int'(miss_err), 1);
    chk("miss_locked", int'(locked), 0);
    chk("miss_errcnt", int'(err_count), 1);
    idle(1);
    chk("miss_one_cycle", int'(miss_err), 0);
    step(1'b1, 1'b0);
    chk("reacq_anchor_locked", int'(locked), 0);
    next_tick();
    next_tick();
    chk("reacq_int2_locked", int'(locked), 0);
    next_tick();
    chk("reacq_locked", int'(locked), 1);

    // ---------------- early tick ----------------
    next_tick();
    idle(2);
    step(1'b1, 1'b0);
    chk("early_flag", int'(short_err), 1);
    chk("early_locked", int'(locked), 0);
    chk("early_errcnt", int'(err_count), 2);
    chk("early_no_miss", int'(miss_err), 0);
    next_tick();
    chk("early_one_cycle", int'(short_err), 0);
    next_tick();
    chk("relock_int2_locked", int'(locked), 0);
    next_tick();
    chk("relock_locked", int'(locked), 1);

    // ---------------- stuck-high ----------------
    s0 = short_cnt;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("stuck_short_pulses", short_cnt - s0, 1);
    chk("stuck_locked", int'(locked), 0);
    chk("stuck_errcnt", int'(err_count), 3);
    step(1'b0, 1'b0);

    // ---------------- saturation ----------------
    m0 = miss_cnt;
    for (int k = 0; k < 5; k++) begin
      acquire();
      idle(5);
      chk("sat_miss_flag", int'(miss_err), 1);
      chk("sat_errcnt", int'(err_count), 3);
    end
    chk("sat_miss_pulses", miss_cnt - m0, 5);

    // sixth error coincident with err_clr
    acquire();
    idle(4);
    step(1'b0, 1'b1);
    chk("clr_miss_flag", int'(miss_err), 1);
    chk("clr_errcnt", int'(err_count), 0);
    idle(1);
    chk("clr_errcnt_hold", int'(err_count), 0);
    acquire();
    idle(5);
    chk("post_clr_errcnt", int'(err_count), 1);

    // ---------------- reset mid-lock ----------------
    acquire();
    idle(2);
    chk("rml_pre_locked", int'(locked), 1);
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    chk("rml_locked", int'(locked), 0);
    chk("rml_errcnt", int'(err_count), 0);
    chk("rml_short", int'(short_err), 0);
    chk("rml_miss", int'(miss_err), 0);
    step(1'b1, 1'b0);
    chk("rml_anchor_locked", int'(locked), 0);
    next_tick();
    next_tick();
    chk("rml_int2_locked", int'(locked), 0);
    next_tick();
    chk("rml_relock", int'(locked), 1);

    chk("never_both_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
